// File: rtl/decode_stage_pipe.sv
// Instruction decode stage: register file, control decode, condition check, ID/EX register.
// Latency: one cycle from an accepted IF->ID transfer to out_valid.
// Backpressure: in_ready drops on hazard or a full, stalled output; flush drains the output register.

// Maps mode/opcode/S onto the execute-stage control word.
module ControlUnit (
  input  logic [1:0] mode,
  input  logic [3:0] opcode,
  input  logic       s,
  output logic [3:0] aluCmd,
  output logic       memRead,
  output logic       memWrite,
  output logic       wbEn,
  output logic       branch,
  output logic       sOut
);
  // Data-processing, load/store and branch classes; unknown encodings decode to a NOP
  always_comb begin
    aluCmd   = 4'h0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    wbEn     = 1'b0;
    branch   = 1'b0;
    sOut     = 1'b0;
    case (mode)
      2'b00: begin
        sOut = s;
        case (opcode)
          4'hD: begin aluCmd = 4'h1; wbEn = 1'b1; end  // MOV
          4'hF: begin aluCmd = 4'h9; wbEn = 1'b1; end  // MVN
          4'h4: begin aluCmd = 4'h2; wbEn = 1'b1; end  // ADD
          4'h5: begin aluCmd = 4'h3; wbEn = 1'b1; end  // ADC
          4'h2: begin aluCmd = 4'h4; wbEn = 1'b1; end  // SUB
          4'h6: begin aluCmd = 4'h5; wbEn = 1'b1; end  // SBC
          4'h0: begin aluCmd = 4'h6; wbEn = 1'b1; end  // AND
          4'hC: begin aluCmd = 4'h7; wbEn = 1'b1; end  // ORR
          4'h1: begin aluCmd = 4'h8; wbEn = 1'b1; end  // EOR
          4'hA: aluCmd = 4'h4;                         // CMP: flags only
          4'h8: aluCmd = 4'h6;                         // TST: flags only
          default: ;
        endcase
      end
      2'b01: begin
        if (opcode == 4'h4) begin
          aluCmd = 4'h2;  // address = Rn + offset
          if (s) begin
            memRead = 1'b1;
            wbEn    = 1'b1;
          end else begin
            memWrite = 1'b1;
          end
        end
      end
      2'b10: branch = 1'b1;
      default: ;
    endcase
  end
endmodule

// Evaluates the condition field against the NZCV flags.
module ConditionCheck (
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       condOk
);
  logic n, z, c, v;
  assign {n, z, c, v} = status;

  // One term per condition code; 1111 is treated as always
  always_comb begin
    condOk = 1'b1;
    case (cond)
      4'h0: condOk = z;
      4'h1: condOk = ~z;
      4'h2: condOk = c;
      4'h3: condOk = ~c;
      4'h4: condOk = n;
      4'h5: condOk = ~n;
      4'h6: condOk = v;
      4'h7: condOk = ~v;
      4'h8: condOk = c & ~z;
      4'h9: condOk = ~c | z;
      4'hA: condOk = (n == v);
      4'hB: condOk = (n != v);
      4'hC: condOk = ~z & (n == v);
      4'hD: condOk = z | (n != v);
      default: condOk = 1'b1;
    endcase
  end
endmodule

module decode_stage_pipe #(
  parameter int DATA_W    = 32,
  parameter int REG_CNT   = 16,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [31:0]       in_inst,
  input  logic [3:0]        status,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              hazard,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [3:0]        out_alu_cmd,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_wb_en,
  output logic              out_branch,
  output logic              out_s,
  output logic [DATA_W-1:0] out_rn_val,
  output logic [DATA_W-1:0] out_rm_val,
  output logic              out_imm,
  output logic [11:0]       out_shift_operand,
  output logic [23:0]       out_imm24,
  output logic [3:0]        out_dest,
  output logic [3:0]        out_src1,
  output logic [3:0]        out_src2,
  output logic              hazard_two_src,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DATA_W-1:0] regFile [REG_CNT];

  logic [3:0]        decAluCmd;
  logic              decMemRead, decMemWrite, decWbEn, decBranch, decS;
  logic              condOk;
  logic [3:0]        rnAddr, rmAddr;
  logic [DATA_W-1:0] rnVal, rmVal;
  logic              wbFwd;
  logic              load;

  ControlUnit uCtrl (
    .mode     (in_inst[27:26]),
    .opcode   (in_inst[24:21]),
    .s        (in_inst[20]),
    .aluCmd   (decAluCmd),
    .memRead  (decMemRead),
    .memWrite (decMemWrite),
    .wbEn     (decWbEn),
    .branch   (decBranch),
    .sOut     (decS)
  );

  ConditionCheck uCond (
    .cond   (in_inst[31:28]),
    .status (status),
    .condOk (condOk)
  );

  // Stores read Rd as their data source, everything else reads Rm
  assign rnAddr = in_inst[19:16];
  assign rmAddr = decMemWrite ? in_inst[15:12] : in_inst[3:0];

  assign hazard_two_src = ~in_inst[25] | decMemWrite;

  // Flush overrides the stall so the killed fetch is consumed; reset holds ready low
  assign in_ready = rst & (flush | (~hazard & (~out_valid | out_ready)));
  assign load     = in_valid & in_ready & ~flush;

  // A write-back only forwards if it would actually land in the array
  assign wbFwd = (WB_BYPASS != 0) && wb_en && (32'(wb_dest) < REG_CNT);

  // Read port 1 with same-cycle write-back forwarding
  always_comb begin
    rnVal = '0;
    if (32'(rnAddr) < REG_CNT) rnVal = regFile[rnAddr];
    if (wbFwd && (wb_dest == rnAddr)) rnVal = wb_value;
  end

  // Read port 2 with same-cycle write-back forwarding
  always_comb begin
    rmVal = '0;
    if (32'(rmAddr) < REG_CNT) rmVal = regFile[rmAddr];
    if (wbFwd && (wb_dest == rmAddr)) rmVal = wb_value;
  end

  // Register file write port; reset clears every register
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_CNT; i++) regFile[i] <= '0;
    end else if (wb_en && (32'(wb_dest) < REG_CNT)) begin
      regFile[wb_dest] <= wb_value;
    end
  end

  // ID/EX register: flush kills, load captures (NOP on failed condition), accept or hazard drains
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid         <= 1'b0;
      out_pc            <= '0;
      out_alu_cmd       <= 4'h0;
      out_mem_read      <= 1'b0;
      out_mem_write     <= 1'b0;
      out_wb_en         <= 1'b0;
      out_branch        <= 1'b0;
      out_s             <= 1'b0;
      out_rn_val        <= '0;
      out_rm_val        <= '0;
      out_imm           <= 1'b0;
      out_shift_operand <= 12'h0;
      out_imm24         <= 24'h0;
      out_dest          <= 4'h0;
      out_src1          <= 4'h0;
      out_src2          <= 4'h0;
    end else if (flush || (!load && out_valid && out_ready)) begin
      out_valid     <= 1'b0;
      out_alu_cmd   <= 4'h0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      out_wb_en     <= 1'b0;
      out_branch    <= 1'b0;
      out_s         <= 1'b0;
    end else if (load) begin
      out_valid         <= 1'b1;
      out_pc            <= in_pc;
      out_alu_cmd       <= condOk ? decAluCmd : 4'h0;
      out_mem_read      <= condOk & decMemRead;
      out_mem_write     <= condOk & decMemWrite;
      out_wb_en         <= condOk & decWbEn;
      out_branch        <= condOk & decBranch;
      out_s             <= condOk & decS;
      out_rn_val        <= rnVal;
      out_rm_val        <= rmVal;
      out_imm           <= in_inst[25];
      out_shift_operand <= in_inst[11:0];
      out_imm24         <= in_inst[23:0];
      out_dest          <= in_inst[15:12];
      out_src1          <= rnAddr;
      out_src2          <= rmAddr;
    end
  end

  // Saturating count of cycles a pending instruction is held by the hazard unit
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (hazard && in_valid && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboarded bench for decode_stage_pipe: stimulus pushes expected ID/EX entries,
// a negedge monitor compares whatever the DUT presents.
module tb_decode_stage_pipe;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        br;
    logic        s;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        imm;
    logic [11:0] shOp;
    logic [23:0] imm24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_pc = '0;
  logic [31:0]       in_inst = '0;
  logic [3:0]        status = '0;
  logic              wb_en = 1'b0;
  logic [3:0]        wb_dest = '0;
  logic [31:0]       wb_value = '0;
  logic              hazard = 1'b0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_pc;
  logic [3:0]        out_alu_cmd;
  logic              out_mem_read, out_mem_write, out_wb_en, out_branch, out_s;
  logic [31:0]       out_rn_val, out_rm_val;
  logic              out_imm;
  logic [11:0]       out_shift_operand;
  logic [23:0]       out_imm24;
  logic [3:0]        out_dest, out_src1, out_src2;
  logic              hazard_two_src;
  logic [CNT_W-1:0]  stall_cnt;

  decode_stage_pipe #(
    .DATA_W(32), .REG_CNT(16), .WB_BYPASS(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .status(status),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .hazard(hazard), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_alu_cmd(out_alu_cmd), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_wb_en(out_wb_en), .out_branch(out_branch),
    .out_s(out_s), .out_rn_val(out_rn_val), .out_rm_val(out_rm_val),
    .out_imm(out_imm), .out_shift_operand(out_shift_operand), .out_imm24(out_imm24),
    .out_dest(out_dest), .out_src1(out_src1), .out_src2(out_src2),
    .hazard_two_src(hazard_two_src), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [31:0]      mRegs [16];
  logic             mValid = 1'b0;
  logic [CNT_W-1:0] mCnt = '0;
  ent_t             expQ [$];
  logic             expInReady = 1'b0;
  logic             expTwoSrc = 1'b0;
  logic             chkOn = 1'b0;

  int nCompared = 0;
  int nMismatch = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Instruction semantics: returns {alu[3:0], memRead, memWrite, wbEn, branch, s}
  function automatic logic [8:0] refDecode(input logic [31:0] inst);
    logic [3:0] op;
    op = inst[24:21];
    if (inst[27:26] == 2'b00) begin
      case (op)
        4'hD: return {4'h1, 4'b0010, inst[20]};   // MOV
        4'hF: return {4'h9, 4'b0010, inst[20]};   // MVN
        4'h4: return {4'h2, 4'b0010, inst[20]};   // ADD
        4'h5: return {4'h3, 4'b0010, inst[20]};   // ADC
        4'h2: return {4'h4, 4'b0010, inst[20]};   // SUB
        4'h6: return {4'h5, 4'b0010, inst[20]};   // SBC
        4'h0: return {4'h6, 4'b0010, inst[20]};   // AND
        4'hC: return {4'h7, 4'b0010, inst[20]};   // ORR
        4'h1: return {4'h8, 4'b0010, inst[20]};   // EOR
        4'hA: return {4'h4, 4'b0000, inst[20]};   // CMP
        4'h8: return {4'h6, 4'b0000, inst[20]};   // TST
        default: return {8'h00, inst[20]};
      endcase
    end
    if (inst[27:26] == 2'b01 && op == 4'h4)
      return inst[20] ? {4'h2, 5'b10100} : {4'h2, 5'b01000};  // LDR / STR
    if (inst[27:26] == 2'b10) return {4'h0, 5'b00010};        // B
    return 9'h0;
  endfunction

  // Condition pairs: even code tests a predicate, odd code its complement, 111x always
  function automatic logic refCond(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, base;
    {n, z, c, v} = nzcv;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: return 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

  function automatic logic [31:0] refRead(input logic [3:0] a, input logic we,
                                          input logic [3:0] wd, input logic [31:0] wv);
    return (we && wd == a) ? wv : mRegs[a];
  endfunction

  // Drive one cycle of inputs, predict the response, then advance past the clock edge
  task automatic doCycle(input logic r, input logic iv, input logic [31:0] pc,
                         input logic [31:0] inst, input logic [3:0] st, input logic we,
                         input logic [3:0] wd, input logic [31:0] wv, input logic hz,
                         input logic fl, input logic ordy);
    logic [8:0] ctl;
    logic       ld, nValid, ok;
    logic [3:0] a2;
    logic [CNT_W-1:0] nCnt;
    ent_t       e;
    rst = r; in_valid = iv; in_pc = pc; in_inst = inst; status = st;
    wb_en = we; wb_dest = wd; wb_value = wv; hazard = hz; flush = fl; out_ready = ordy;
    ctl        = refDecode(inst);
    expInReady = r & (fl | (~hz & (~mValid | ordy)));
    expTwoSrc  = ~inst[25] | ctl[3];
    ld         = iv & expInReady & ~fl;
    if (ld) begin
      ok      = refCond(inst[31:28], st);
      a2      = ctl[3] ? inst[15:12] : inst[3:0];
      e.pc    = pc;
      {e.alu, e.mr, e.mw, e.wb, e.br, e.s} = ok ? ctl : 9'h0;
      e.rn    = refRead(inst[19:16], we, wd, wv);
      e.rm    = refRead(a2, we, wd, wv);
      e.imm   = inst[25];
      e.shOp  = inst[11:0];
      e.imm24 = inst[23:0];
      e.dest  = inst[15:12];
      e.src1  = inst[19:16];
      e.src2  = a2;
      expQ.push_back(e);
    end
    if (!r || fl)         nValid = 1'b0;
    else if (ld)          nValid = 1'b1;
    else if (mValid && ordy) nValid = 1'b0;
    else                  nValid = mValid;
    if (!r)                           nCnt = '0;
    else if (hz && iv && !(&mCnt))    nCnt = mCnt + 1'b1;
    else                              nCnt = mCnt;
    @(posedge clk);
    mValid = nValid;
    mCnt   = nCnt;
    if (!r) begin
      for (int i = 0; i < 16; i++) mRegs[i] = '0;
      expQ.delete();
    end else if (we) begin
      mRegs[wd] = wv;
    end
    #1;
  endtask

  task automatic idle(input logic r, input logic ordy);
    doCycle(r, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, ordy);
  endtask

  task automatic writeReg(input logic [3:0] a, input logic [31:0] v);
    doCycle(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a, v, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: handshake/side outputs every cycle, payload whenever an entry is presented
  always @(negedge clk) begin
    if (chkOn) begin
      ent_t got;
      chk("in_ready", 192'(in_ready), 192'(expInReady));
      chk("out_valid", 192'(out_valid), 192'(mValid));
      chk("hazard_two_src", 192'(hazard_two_src), 192'(expTwoSrc));
      chk("stall_cnt", 192'(stall_cnt), 192'(mCnt));
      if (out_valid) begin
        chk("entry_present", 192'(expQ.size() != 0), 192'(1'b1));
        if (expQ.size() != 0) begin
          got.pc = out_pc; got.alu = out_alu_cmd; got.mr = out_mem_read;
          got.mw = out_mem_write; got.wb = out_wb_en; got.br = out_branch; got.s = out_s;
          got.rn = out_rn_val; got.rm = out_rm_val; got.imm = out_imm;
          got.shOp = out_shift_operand; got.imm24 = out_imm24; got.dest = out_dest;
          got.src1 = out_src1; got.src2 = out_src2;
          chk("payload", 192'(got), 192'(expQ[0]));
          if (out_ready || flush || !rst) void'(expQ.pop_front());
        end
      end
    end
  end

  localparam logic [31:0] ADD_R1 = 32'hE0821003;  // ADD r1,r2,r3
  localparam logic [31:0] STR_R4 = 32'hE4824000;  // STR r4,[r2]
  localparam logic [31:0] ADDEQ  = 32'h00821003;  // ADDEQ r1,r2,r3
  localparam logic [31:0] ORR_R6 = 32'hE1826003;  // ORR r6,r2,r3

  initial begin
    for (int i = 0; i < 16; i++) mRegs[i] = '0;
    idle(1'b0, 1'b0);
    chkOn = 1'b1;
    idle(1'b0, 1'b0);

    // Preload all registers, hold an entry, then reset mid-transfer
    for (int i = 0; i < 16; i++) writeReg(4'(i), 32'h1000 + 32'(i) * 32'h11);
    doCycle(1'b1, 1'b1, 32'h80, ADD_R1, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    doCycle(1'b1, 1'b1, 32'h84, ORR_R6, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    doCycle(1'b0, 1'b1, 32'h84, ORR_R6, 4'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("rst_out_valid", 192'(out_valid), 192'(1'b0));
    chk("rst_rn_val", 192'(out_rn_val), 192'(32'h0));
    chk("rst_pc", 192'(out_pc), 192'(32'h0));
    chk("rst_stall_cnt", 192'(stall_cnt), 192'(4'h0));

    // ADD r1,r2,r3 with r2=5, r3=7
    writeReg(4'd2, 32'd5);
    writeReg(4'd3, 32'd7);
    doCycle(1'b1, 1'b1, 32'h100, ADD_R1, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("add_valid", 192'(out_valid), 192'(1'b1));
    chk("add_rn", 192'(out_rn_val), 192'(32'd5));
    chk("add_rm", 192'(out_rm_val), 192'(32'd7));
    chk("add_dest", 192'(out_dest), 192'(4'd1));
    chk("add_wb_en", 192'(out_wb_en), 192'(1'b1));
    idle(1'b1, 1'b1);

    // STR r4,[r2] with r4 written back in the same cycle
    doCycle(1'b1, 1'b1, 32'h104, STR_R4, 4'h0, 1'b1, 4'd4, 32'hAA, 1'b0, 1'b0, 1'b1);
    chk("str_rm_bypass", 192'(out_rm_val), 192'(32'hAA));
    chk("str_mem_write", 192'(out_mem_write), 192'(1'b1));
    idle(1'b1, 1'b1);

    // EQ with Z clear becomes a NOP but keeps its PC
    doCycle(1'b1, 1'b1, 32'h1234, ADDEQ, 4'b0000, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("eq_valid", 192'(out_valid), 192'(1'b1));
    chk("eq_ctrl", 192'({out_alu_cmd, out_mem_read, out_mem_write, out_wb_en, out_branch, out_s}),
        192'(9'h0));
    chk("eq_pc", 192'(out_pc), 192'(32'h1234));
    idle(1'b1, 1'b1);

    // Downstream stall for 3 cycles, then hazard for 2, then resume
    doCycle(1'b1, 1'b1, 32'h200, ADD_R1, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      doCycle(1'b1, 1'b1, 32'h204, ORR_R6, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      doCycle(1'b1, 1'b1, 32'h204, ORR_R6, 4'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("stall_held_pc", 192'(out_pc), 192'(32'h200));
    chk("stall_cnt_two", 192'(stall_cnt), 192'(4'd2));
    doCycle(1'b1, 1'b1, 32'h204, ORR_R6, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("resume_pc", 192'(out_pc), 192'(32'h204));
    idle(1'b1, 1'b1);

    // Flush with an entry held and a new instruction offered
    doCycle(1'b1, 1'b1, 32'h300, ADD_R1, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    doCycle(1'b1, 1'b1, 32'h304, ORR_R6, 4'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("flush_out_valid", 192'(out_valid), 192'(1'b0));
    idle(1'b1, 1'b1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] inst;
      logic        fl, ordy;
      inst = $urandom;
      inst[27:26] = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) inst[24:21] = 4'h4;
      if ($urandom_range(0, 1) == 1) inst[31:28] = 4'hE;
      fl   = ($urandom_range(0, 99) < 8);
      ordy = fl ? 1'b0 : ($urandom_range(0, 9) < 7);
      doCycle($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, $urandom, inst,
              4'($urandom), 1'($urandom), 4'($urandom), $urandom,
              $urandom_range(0, 9) < 2, fl, ordy);
    end

    for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);
    chk("queue_drained", 192'(expQ.size()), 192'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

Parameters
REQ-001 DATA_W, 32, register/data/PC width.
REQ-002 REG_CNT, 16, implemented architectural registers (1..16); 4-bit register fields are fixed by the instruction encoding.
REQ-003 WB_BYPASS, 1, 1 = a same-cycle write-back value is forwarded onto the read ports.
REQ-004 CNT_W, 16, stall counter width.

Interface
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 in_valid / in_ready  in / out  1 / 1  IF->ID handshake.
REQ-008 in_pc, in_inst  in  DATA_W / 32  fetched PC and instruction.
REQ-009 status  in  4  NZCV flags for the condition check.
REQ-010 wb_en, wb_dest, wb_value  in  1 / 4 / DATA_W  register-file write port.
REQ-011 hazard  in  1  stall request from the hazard unit.
REQ-012 flush  in  1  kill request on a taken branch.
REQ-013 out_valid / out_ready  out / in  1 / 1  ID->EX handshake.
REQ-014 out_pc, out_alu_cmd, out_mem_read, out_mem_write, out_wb_en, out_branch, out_s  out  DATA_W,4,1,1,1,1,1  registered payload.
REQ-015 out_rn_val, out_rm_val  out  DATA_W  registered operand values.
REQ-016 out_imm, out_shift_operand, out_imm24, out_dest, out_src1, out_src2  out  1,12,24,4,4,4  registered fields.
REQ-017 hazard_two_src  out  1  combinational: ~in_inst[25] | decoded memWrite.
REQ-018 stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-019 Decoding SHALL use the team ControlUnit (mode=[27:26], opcode=[24:21], S=[20]) and ConditionCheck (cond=[31:28]).
REQ-020 Register file: REG_CNT x DATA_W; combinational reads; write on the clock edge when wb_en=1 and wb_dest<REG_CNT; reads with index>=REG_CNT SHALL return 0.
REQ-021 Read port 1 address = inst[19:16]; port 2 address = inst[15:12] if decoded memWrite=1, otherwise inst[3:0].
REQ-022 WB_BYPASS=1: when wb_en=1 and wb_dest equals a read address, that port SHALL return wb_value in the same cycle.
REQ-023 in_ready = ~hazard & (~out_valid | out_ready), overridden to 1 while flush=1.
REQ-024 load = in_valid & in_ready & ~flush; on load, the output register captures all payload fields; out_valid<=1 at the next edge (latency 1 cycle).
REQ-025 Condition false on load: the entry SHALL be captured with out_valid=1 and alu_cmd, mem_read, mem_write, wb_en, branch and s all forced to 0 (architectural NOP).
REQ-026 out_valid=1 & out_ready=0 & ~flush: all outputs SHALL hold exactly.
REQ-027 Output accepted (out_valid & out_ready) with no load: out_valid<=0 and control bits<=0.
REQ-028 hazard=1 & ~flush: nothing is loaded; if the output register is drained that cycle, a bubble (out_valid=0, control=0) is inserted; the upstream instruction stays pending.
REQ-029 flush=1: out_valid<=0 and control bits<=0 regardless of the other inputs; the incoming instruction is discarded; flush has the highest priority after reset.
REQ-030 stall_cnt increments once per cycle with hazard=1 & in_valid=1 and saturates at 2^CNT_W-1.
REQ-031 Simultaneous accept and load: the new entry replaces the old entry with no bubble, giving full throughput of 1 instruction per cycle.

Reset
REQ-032 rst=0 at a clock edge: out_valid=0, every out_* field=0, stall_cnt=0, all registers=0.
REQ-033 Reset asserted mid-transfer SHALL drop the held entry; in_ready SHALL be 0 while rst=0.

Verification
REQ-034 Reset with all registers preloaded -> next cycle out_valid=0, out_rn_val=0, stall_cnt=0.
REQ-035 ADD r1,r2,r3 (AL) with r2=5, r3=7, out_ready=1 -> one cycle later out_valid=1, out_rn_val=5, out_rm_val=7, out_dest=1, out_wb_en=1.
REQ-036 STR r4,[r2] with wb_en=1, wb_dest=4, wb_value=0xAA in the same cycle -> out_rm_val=0xAA, out_mem_write=1.
REQ-037 EQ instruction with Z=0 -> out_valid=1 with all control bits 0 and out_pc=in_pc.
REQ-038 out_ready=0 for 3 cycles, then hazard=1 for 2 cycles -> outputs stable, in_ready=0, stall_cnt=2, then resume with no loss or duplicate.
REQ-039 flush=1 together with in_valid=1 and a held entry -> next cycle out_valid=0, in_ready=1 during the flush, instruction dropped.
